// File: rtl/sprite_commit_if.sv
// CPU-side write/commit port and engine-side config port of the sprite commit scheduler.
// Handshake: a write is accepted on any clk edge where wr_valid && wr_ready; wr_valid while !wr_ready is dropped.
interface sprite_commit_if #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              vblank;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              commit;
    logic              irq_clr;
    logic              eng_wr_en;
    logic [ADDR_W-1:0] eng_addr;
    logic [DATA_W-1:0] eng_data;
    logic [LVL_W-1:0]  level;
    logic              busy;
    logic              overflow;
    logic              done_irq;
    logic [1:0]        state_dbg;

    modport master (
        output vblank, wr_valid, wr_addr, wr_data, commit, irq_clr,
        input  wr_ready, eng_wr_en, eng_addr, eng_data, level, busy,
               overflow, done_irq, state_dbg
    );

    modport slave (
        input  vblank, wr_valid, wr_addr, wr_data, commit, irq_clr,
        output wr_ready, eng_wr_en, eng_addr, eng_data, level, busy,
               overflow, done_irq, state_dbg
    );
endinterface

// File: rtl/sprite_commit_scheduler.sv
// Buffers CPU sprite-register writes and replays a committed batch to the sprite
// engine only during vertical blanking, so sprites never change mid-frame.
module sprite_commit_scheduler #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    sprite_commit_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] ONE_LVL  = LVL_W'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [ADDR_W+DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [LVL_W-1:0]         level;
    logic [LVL_W-1:0]         bcnt;
    logic [1:0]               state;
    logic                     vblank_d;
    logic                     eng_wr_en;
    logic [ADDR_W-1:0]        eng_addr;
    logic [DATA_W-1:0]        eng_data;
    logic                     overflow;
    logic                     done_irq;

    logic wr_ready;
    logic push;
    logic pop;
    logic vblank_rise;
    logic done_set;
    logic ovf_set;

    assign wr_ready    = (level != FULL_LVL);
    assign push        = bus.wr_valid && wr_ready;
    assign pop         = (state == S_DRAIN) && bus.vblank && (bcnt != '0);
    assign vblank_rise = bus.vblank && !vblank_d;
    // An empty commit completes at once; otherwise the last pop of the batch completes it.
    assign done_set    = ((state == S_IDLE) && bus.commit && (level == '0)) ||
                         (pop && (bcnt == ONE_LVL));
    assign ovf_set     = bus.wr_valid && !wr_ready;

    // Storage has no reset: only entries between rd_ptr and wr_ptr are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.wr_addr, bus.wr_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            bcnt      <= '0;
            state     <= S_IDLE;
            vblank_d  <= 1'b0;
            eng_wr_en <= 1'b0;
            eng_addr  <= '0;
            eng_data  <= '0;
            overflow  <= 1'b0;
            done_irq  <= 1'b0;
        end else begin
            vblank_d <= bus.vblank;

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + ONE_LVL;
                2'b01:   level <= level - ONE_LVL;
                default: level <= level;
            endcase

            eng_wr_en <= pop;
            if (pop) begin
                {eng_addr, eng_data} <= mem[rd_ptr];
            end

            case (state)
                S_IDLE: begin
                    // Snapshot excludes a push landing on this same edge.
                    if (bus.commit && (level != '0)) begin
                        bcnt  <= level;
                        state <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (vblank_rise) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!bus.vblank) begin
                        state <= S_ARMED;
                    end else if (pop) begin
                        bcnt <= bcnt - ONE_LVL;
                        if (bcnt == ONE_LVL) begin
                            state <= S_IDLE;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (done_set) begin
                done_irq <= 1'b1;
            end else if (bus.irq_clr) begin
                done_irq <= 1'b0;
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (bus.irq_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    assign bus.wr_ready  = wr_ready;
    assign bus.eng_wr_en = eng_wr_en;
    assign bus.eng_addr  = eng_addr;
    assign bus.eng_data  = eng_data;
    assign bus.level     = level;
    assign bus.busy      = (state != S_IDLE);
    assign bus.overflow  = overflow;
    assign bus.done_irq  = done_irq;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_sprite_commit_scheduler.sv
// Directed bench for sprite_commit_scheduler: queued writes are pushed to an expected
// queue at issue time and a monitor pops/compares every engine strobe.
module tb_sprite_commit_scheduler;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 16;
    localparam int EW     = ADDR_W + DATA_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sprite_commit_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sprite_commit_scheduler #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [EW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int strobe_cnt = 0;
    int base;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every engine strobe must match the oldest outstanding write.
    always @(negedge clk) begin
        if (rst_n && bus.eng_wr_en === 1'b1) begin
            strobe_cnt++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL eng_write: unexpected strobe addr 0x%0h data 0x%0h at %0t",
                         bus.eng_addr, bus.eng_data, $time);
            end else begin
                check("eng_write", 32'({bus.eng_addr, bus.eng_data}), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit accept);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        if (accept) exp_q.push_back({a, d});
        cyc(1);
        bus.wr_valid = 1'b0;
    endtask

    task automatic pulse_commit();
        bus.commit = 1'b1;
        cyc(1);
        bus.commit = 1'b0;
    endtask

    task automatic pulse_clr();
        bus.irq_clr = 1'b1;
        cyc(1);
        bus.irq_clr = 1'b0;
    endtask

    task automatic wait_strobes(input int target, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (strobe_cnt >= target) return;
        end
        n_cmp++;
        n_err++;
        $display("FAIL %s: timeout, strobes %0d, wanted %0d", name, strobe_cnt, target);
    endtask

    initial begin
        bus.vblank   = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.commit   = 1'b0;
        bus.irq_clr  = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);

        // Reset state
        check("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
        check("rst_level", 32'(bus.level), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_eng_wr_en", 32'(bus.eng_wr_en), 32'd0);
        check("rst_flags", 32'({bus.overflow, bus.done_irq}), 32'd0);

        // Batch of 3 held off while vblank stays low
        push(6'h04, 16'h1020, 1'b1);
        push(6'h06, 16'hAAAA, 1'b1);
        push(6'h08, 16'h5555, 1'b1);
        pulse_commit();
        base = strobe_cnt;
        cyc(20);
        check("hold_strobes", 32'(strobe_cnt - base), 32'd0);
        check("hold_busy", 32'(bus.busy), 32'd1);
        check("hold_level", 32'(bus.level), 32'd3);
        check("hold_state", 32'(bus.state_dbg), 32'd1);

        // vblank rises: strobes on cycles 2..4 after the rise
        bus.vblank = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            cyc(1);
            check($sformatf("rise_en_k%0d", k), 32'(bus.eng_wr_en), (k >= 2 && k <= 4) ? 32'd1 : 32'd0);
            check($sformatf("rise_done_k%0d", k), 32'(bus.done_irq), (k >= 4) ? 32'd1 : 32'd0);
        end
        check("rise_strobes", 32'(strobe_cnt - base), 32'd3);
        check("rise_busy", 32'(bus.busy), 32'd0);
        check("rise_level", 32'(bus.level), 32'd0);
        pulse_clr();
        check("clr_done", 32'(bus.done_irq), 32'd0);
        bus.vblank = 1'b0;
        cyc(2);

        // Fill to DEPTH, 9th write dropped
        for (int i = 0; i < DEPTH; i++) push(6'(8'h10 + i), 16'(16'hC000 + i), 1'b1);
        check("full_level_pre", 32'(bus.level), 32'd8);
        push(6'h3F, 16'hDEAD, 1'b0);
        check("full_wr_ready", 32'(bus.wr_ready), 32'd0);
        check("full_overflow", 32'(bus.overflow), 32'd1);
        check("full_level", 32'(bus.level), 32'd8);
        pulse_commit();
        base = strobe_cnt;
        cyc(2);
        bus.vblank = 1'b1;
        wait_strobes(base + 8, 40, "full_drain");
        cyc(3);
        check("full_strobes", 32'(strobe_cnt - base), 32'd8);
        check("full_level_post", 32'(bus.level), 32'd0);
        check("full_done", 32'(bus.done_irq), 32'd1);
        check("full_ovf_kept", 32'(bus.overflow), 32'd1);
        pulse_clr();
        check("full_clr_flags", 32'({bus.overflow, bus.done_irq}), 32'd0);
        bus.vblank = 1'b0;
        cyc(2);

        // Batch of 5 split across two blanking intervals
        for (int i = 0; i < 5; i++) push(6'(8'h20 + i), 16'(16'h0F00 + 16'(i * 16'h11)), 1'b1);
        pulse_commit();
        cyc(2);
        base = strobe_cnt;
        bus.vblank = 1'b1;
        cyc(3);
        bus.vblank = 1'b0;
        cyc(1);
        check("split_strobes_a", 32'(strobe_cnt - base), 32'd2);
        check("split_state", 32'(bus.state_dbg), 32'd1);
        check("split_level", 32'(bus.level), 32'd3);
        check("split_done_a", 32'(bus.done_irq), 32'd0);
        cyc(3);
        check("split_idle_gap", 32'(strobe_cnt - base), 32'd2);
        bus.vblank = 1'b1;
        wait_strobes(base + 5, 20, "split_drain");
        cyc(1);
        check("split_done_b", 32'(bus.done_irq), 32'd1);
        check("split_level_b", 32'(bus.level), 32'd0);
        check("split_state_b", 32'(bus.state_dbg), 32'd0);
        pulse_clr();
        bus.vblank = 1'b0;
        cyc(2);

        // Entry pushed while ARMED waits for the next commit
        push(6'h30, 16'h1234, 1'b1);
        push(6'h31, 16'h5678, 1'b1);
        pulse_commit();
        push(6'h32, 16'h9ABC, 1'b1);
        base = strobe_cnt;
        bus.vblank = 1'b1;
        wait_strobes(base + 2, 20, "late_drain");
        cyc(3);
        check("late_strobes", 32'(strobe_cnt - base), 32'd2);
        check("late_level", 32'(bus.level), 32'd1);
        check("late_busy", 32'(bus.busy), 32'd0);
        check("late_done", 32'(bus.done_irq), 32'd1);
        pulse_clr();
        bus.vblank = 1'b0;
        cyc(2);
        pulse_commit();
        base = strobe_cnt;
        bus.vblank = 1'b1;
        wait_strobes(base + 1, 20, "late_drain2");
        cyc(2);
        check("late2_strobes", 32'(strobe_cnt - base), 32'd1);
        check("late2_level", 32'(bus.level), 32'd0);
        check("late2_done", 32'(bus.done_irq), 32'd1);
        pulse_clr();
        bus.vblank = 1'b0;
        cyc(2);

        // Empty commit completes at once; set beats a simultaneous clear
        pulse_commit();
        check("empty_done", 32'(bus.done_irq), 32'd1);
        check("empty_busy", 32'(bus.busy), 32'd0);
        pulse_clr();
        check("empty_clr", 32'(bus.done_irq), 32'd0);
        bus.commit  = 1'b1;
        bus.irq_clr = 1'b1;
        cyc(1);
        bus.commit  = 1'b0;
        bus.irq_clr = 1'b0;
        check("set_wins", 32'(bus.done_irq), 32'd1);
        pulse_clr();
        cyc(1);

        // Reset mid-drain with 4 entries left
        for (int i = 0; i < 6; i++) push(6'(8'h01 + i), 16'(16'hB000 + i), 1'b1);
        pulse_commit();
        base = strobe_cnt;
        bus.vblank = 1'b1;
        wait_strobes(base + 2, 20, "rst_drain");
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("mid_rst_eng_wr_en", 32'(bus.eng_wr_en), 32'd0);
        check("mid_rst_level", 32'(bus.level), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done", 32'(bus.done_irq), 32'd0);
        bus.vblank = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        base = strobe_cnt;
        bus.vblank = 1'b1;
        cyc(10);
        check("post_rst_strobes", 32'(strobe_cnt - base), 32'd0);
        check("post_rst_level", 32'(bus.level), 32'd0);
        check("post_rst_busy", 32'(bus.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
